// File: rtl/dma_xfer_ctl.sv
// Block-transfer sequencer for an am2940 DMA address generator: programs the slice,
// then arbitrates for the bus and steps the address/word counters once per acknowledged cycle.
module dma_xfer_ctl #(
  parameter int unsigned W = 8
) (
  input  logic         cp,
  input  logic         rst,
  input  logic         start,
  input  logic [2:0]   mode,
  input  logic [W-1:0] addr,
  input  logic [W-1:0] count,
  input  logic         abort,
  output logic [2:0]   i,
  output logic [W-1:0] dout,
  output logic         doe,
  output logic         aci_,
  output logic         wci_,
  output logic         oea_,
  input  logic         done,
  output logic         breq,
  input  logic         bgnt,
  output logic         mreq,
  input  logic         mack,
  output logic         busy,
  output logic         irq,
  output logic         abt
);

  typedef enum logic [2:0] {
    StIdle,
    StWrcr,
    StLdar,
    StLdwc,
    StReq,
    StXfer,
    StStep,
    StFin
  } state_e;

  state_e       state_q;
  logic [2:0]   mode_q;
  logic [W-1:0] addr_q;
  logic [W-1:0] count_q;
  logic         last_q;
  logic         abt_q;

  always_ff @(posedge cp) begin
    if (rst) begin
      state_q <= StIdle;
      mode_q  <= '0;
      addr_q  <= '0;
      count_q <= '0;
      last_q  <= 1'b0;
      abt_q   <= 1'b0;
    end else if (abort && (state_q != StIdle)) begin
      // Abort wins over grant and acknowledge, so no STEP or irq can follow.
      state_q <= StIdle;
      abt_q   <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            mode_q  <= mode;
            addr_q  <= addr;
            count_q <= count;
            abt_q   <= 1'b0;
            state_q <= StWrcr;
          end
        end
        StWrcr: state_q <= StLdar;
        StLdar: state_q <= StLdwc;
        StLdwc: state_q <= StReq;
        StReq: begin
          if (bgnt) state_q <= StXfer;
        end
        StXfer: begin
          if (mack) begin
            last_q  <= done;
            state_q <= StStep;
          end
        end
        StStep: begin
          if (last_q)    state_q <= StFin;
          else if (bgnt) state_q <= StXfer;
          else           state_q <= StReq;
        end
        StFin:   state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    i    = 3'b111;
    dout = '0;
    doe  = 1'b0;
    aci_ = 1'b1;
    wci_ = 1'b1;
    oea_ = 1'b1;
    breq = 1'b0;
    mreq = 1'b0;
    irq  = 1'b0;
    unique case (state_q)
      StWrcr: begin
        i    = 3'b000;
        doe  = 1'b1;
        dout = W'(mode_q);
      end
      StLdar: begin
        i    = 3'b101;
        doe  = 1'b1;
        dout = addr_q;
      end
      StLdwc: begin
        i    = 3'b110;
        doe  = 1'b1;
        dout = count_q;
      end
      StReq: breq = 1'b1;
      StXfer: begin
        breq = 1'b1;
        mreq = 1'b1;
        oea_ = 1'b0;
      end
      StStep: begin
        breq = 1'b1;
        aci_ = 1'b0;
        wci_ = 1'b0;
      end
      StFin:   irq = 1'b1;
      default: ;
    endcase
  end

  assign busy = (state_q != StIdle);
  assign abt  = abt_q;

endmodule

// File: tb/tb_dma_xfer_ctl.sv
// Directed bench for dma_xfer_ctl with a minimal am2940 address/word-count model attached.
module tb_dma_xfer_ctl;

  logic       cp = 1'b0;
  logic       rst, start, abort, bgnt, mack;
  logic [2:0] mode;
  logic [7:0] addr, count;
  logic [2:0] i;
  logic [7:0] dout;
  logic       doe, aci_, wci_, oea_, done, breq, mreq, busy, irq, abt;

  int n_chk  = 0;
  int n_fail = 0;

  // am2940 model: address counter and word counter, done when one word remains.
  logic [7:0] m_ac = '0;
  logic [7:0] m_wc = '0;
  assign done = (m_wc == 8'd1);

  always @(posedge cp) begin
    if (doe && i == 3'b101) m_ac <= dout;
    else if (!aci_)         m_ac <= m_ac + 8'd1;
    if (doe && i == 3'b110) m_wc <= dout;
    else if (!wci_)         m_wc <= m_wc - 8'd1;
  end

  always #5 cp = ~cp;

  dma_xfer_ctl #(.W(8)) dut (
    .cp(cp), .rst(rst), .start(start), .mode(mode), .addr(addr), .count(count),
    .abort(abort), .i(i), .dout(dout), .doe(doe), .aci_(aci_), .wci_(wci_),
    .oea_(oea_), .done(done), .breq(breq), .bgnt(bgnt), .mreq(mreq), .mack(mack),
    .busy(busy), .irq(irq), .abt(abt)
  );

  // Start pulse, then advance to cycle k+4 (REQ state).
  task automatic launch(input logic [2:0] m, input logic [7:0] a, input logic [7:0] c);
    mode = m; addr = a; count = c;
    start = 1'b1;
    @(negedge cp);
    start = 1'b0;
    repeat (3) @(negedge cp);
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; abort = 1'b0; bgnt = 1'b0; mack = 1'b0;
    mode = '0; addr = '0; count = '0;
    repeat (2) @(negedge cp);
    rst = 1'b0;
    n_chk++;
    if ({i, aci_, wci_, oea_, doe, breq, mreq, busy, irq, abt} !== {3'b111, 3'b111, 6'b0}) begin
      n_fail++;
      $display("FAIL reset_idle: got i=%b aci=%b wci=%b oea=%b doe=%b breq=%b mreq=%b busy=%b irq=%b abt=%b",
               i, aci_, wci_, oea_, doe, breq, mreq, busy, irq, abt);
    end
    n_chk++;
    if (dout !== 8'h00) begin n_fail++; $display("FAIL reset_dout: got %h want 00", dout); end
  endtask

  task automatic test_basic;
    bgnt = 1'b1; mack = 1'b1;
    mode = 3'b000; addr = 8'h08; count = 8'h03;
    start = 1'b1;
    @(negedge cp);
    start = 1'b0;
    n_chk++;
    if ({i, doe, dout} !== {3'b000, 1'b1, 8'h00}) begin
      n_fail++; $display("FAIL basic_wrcr: got i=%b doe=%b dout=%h want 000/1/00", i, doe, dout);
    end
    @(negedge cp);
    n_chk++;
    if ({i, doe, dout} !== {3'b101, 1'b1, 8'h08}) begin
      n_fail++; $display("FAIL basic_ldar: got i=%b doe=%b dout=%h want 101/1/08", i, doe, dout);
    end
    @(negedge cp);
    n_chk++;
    if ({i, doe, dout} !== {3'b110, 1'b1, 8'h03}) begin
      n_fail++; $display("FAIL basic_ldwc: got i=%b doe=%b dout=%h want 110/1/03", i, doe, dout);
    end
    @(negedge cp);
    n_chk++;
    if ({breq, mreq, doe, busy} !== 4'b1001) begin
      n_fail++; $display("FAIL basic_req: got breq=%b mreq=%b doe=%b busy=%b want 1001", breq, mreq, doe, busy);
    end
    for (int p = 0; p < 3; p++) begin
      @(negedge cp);
      n_chk++;
      if ({mreq, oea_, aci_, wci_, m_ac} !== {4'b1011, 8'h08 + 8'(p)}) begin
        n_fail++;
        $display("FAIL basic_xfer%0d: got mreq=%b oea=%b aci=%b wci=%b A=%h want 1011 A=%h",
                 p, mreq, oea_, aci_, wci_, m_ac, 8'h08 + 8'(p));
      end
      @(negedge cp);
      n_chk++;
      if ({mreq, aci_, wci_, breq, irq} !== 5'b00010) begin
        n_fail++;
        $display("FAIL basic_step%0d: got mreq=%b aci=%b wci=%b breq=%b irq=%b want 00010",
                 p, mreq, aci_, wci_, breq, irq);
      end
    end
    @(negedge cp); // cycle k+11
    n_chk++;
    if ({irq, breq, m_ac} !== {2'b10, 8'h0B}) begin
      n_fail++; $display("FAIL basic_irq: got irq=%b breq=%b A=%h want irq=1 breq=0 A=0b", irq, breq, m_ac);
    end
    @(negedge cp);
    n_chk++;
    if ({busy, irq, abt} !== 3'b000) begin
      n_fail++; $display("FAIL basic_idle: got busy=%b irq=%b abt=%b want 000", busy, irq, abt);
    end
  endtask

  task automatic test_grant_loss;
    int irqs;
    bgnt = 1'b1; mack = 1'b1;
    mode = 3'b010; addr = 8'h20; count = 8'h03;
    start = 1'b1;
    @(negedge cp);
    start = 1'b0;
    n_chk++;
    if (dout !== 8'h02) begin n_fail++; $display("FAIL grant_mode_dout: got %h want 02", dout); end
    repeat (3) @(negedge cp); // REQ
    @(negedge cp);            // XFER
    @(negedge cp);            // STEP
    bgnt = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge cp);
      n_chk++;
      if ({breq, mreq, aci_, oea_} !== 4'b1011) begin
        n_fail++; $display("FAIL grant_req%0d: got breq=%b mreq=%b aci=%b oea=%b want 1011",
                           c, breq, mreq, aci_, oea_);
      end
    end
    bgnt = 1'b1;
    @(negedge cp);
    n_chk++;
    if ({mreq, oea_, m_ac} !== {2'b10, 8'h21}) begin
      n_fail++; $display("FAIL grant_resume: got mreq=%b oea=%b A=%h want mreq=1 oea=0 A=21", mreq, oea_, m_ac);
    end
    irqs = 0;
    repeat (12) begin
      @(negedge cp);
      if (irq) irqs++;
    end
    n_chk++;
    if (irqs != 1 || busy !== 1'b0 || m_ac !== 8'h23) begin
      n_fail++; $display("FAIL grant_finish: got irqs=%0d busy=%b A=%h want 1/0/23", irqs, busy, m_ac);
    end
  endtask

  task automatic test_slow_mem;
    bgnt = 1'b1; mack = 1'b0;
    launch(3'b000, 8'h50, 8'h01);
    for (int c = 0; c < 3; c++) begin
      @(negedge cp);
      n_chk++;
      if ({mreq, oea_, aci_, wci_} !== 4'b1011) begin
        n_fail++; $display("FAIL slow_xfer%0d: got mreq=%b oea=%b aci=%b wci=%b want 1011",
                           c, mreq, oea_, aci_, wci_);
      end
    end
    mack = 1'b1;
    @(negedge cp);
    n_chk++;
    if ({aci_, wci_, mreq} !== 3'b000) begin
      n_fail++; $display("FAIL slow_step: got aci=%b wci=%b mreq=%b want 000", aci_, wci_, mreq);
    end
    @(negedge cp);
    n_chk++;
    if ({irq, m_ac} !== {1'b1, 8'h51}) begin
      n_fail++; $display("FAIL slow_irq: got irq=%b A=%h want 1/51", irq, m_ac);
    end
    @(negedge cp);
  endtask

  task automatic test_abort;
    bgnt = 1'b1; mack = 1'b0;
    launch(3'b000, 8'h40, 8'h03);
    @(negedge cp); // XFER
    abort = 1'b1; mack = 1'b1;
    @(negedge cp);
    abort = 1'b0; mack = 1'b0;
    n_chk++;
    if ({busy, abt, irq, aci_, wci_, m_ac} !== {5'b01011, 8'h40}) begin
      n_fail++; $display("FAIL abort_collide: got busy=%b abt=%b irq=%b aci=%b wci=%b A=%h want 01011 A=40",
                         busy, abt, irq, aci_, wci_, m_ac);
    end
    repeat (2) @(negedge cp);
    n_chk++;
    if ({busy, abt, irq, m_ac} !== {3'b010, 8'h40}) begin
      n_fail++; $display("FAIL abort_sticky: got busy=%b abt=%b irq=%b A=%h want 010 A=40", busy, abt, irq, m_ac);
    end
  endtask

  task automatic test_reset_midxfer;
    // Previous abort leaves abt set; reset in IDLE must clear it.
    rst = 1'b1;
    @(negedge cp);
    rst = 1'b0;
    n_chk++;
    if (abt !== 1'b0) begin n_fail++; $display("FAIL rst_abt: got abt=%b want 0", abt); end
    bgnt = 1'b1; mack = 1'b0;
    launch(3'b000, 8'h60, 8'h02);
    @(negedge cp); // XFER
    rst = 1'b1; mack = 1'b1; abort = 1'b1; start = 1'b1;
    @(negedge cp);
    rst = 1'b0; mack = 1'b0; abort = 1'b0; start = 1'b0;
    n_chk++;
    if ({i, aci_, wci_, oea_, doe, breq, mreq, busy, irq, abt} !== {3'b111, 3'b111, 6'b0}) begin
      n_fail++;
      $display("FAIL rst_midxfer: got i=%b aci=%b wci=%b oea=%b doe=%b breq=%b mreq=%b busy=%b irq=%b abt=%b",
               i, aci_, wci_, oea_, doe, breq, mreq, busy, irq, abt);
    end
  endtask

  task automatic test_busy_start;
    int irqs;
    bgnt = 1'b0; mack = 1'b1;
    launch(3'b000, 8'h10, 8'h02);
    n_chk++;
    if ({breq, busy} !== 2'b11) begin
      n_fail++; $display("FAIL busy_req: got breq=%b busy=%b want 11", breq, busy);
    end
    start = 1'b1; addr = 8'hA0; count = 8'h05;
    @(negedge cp);
    start = 1'b0; bgnt = 1'b1;
    irqs = 0;
    repeat (20) begin
      @(negedge cp);
      if (irq) irqs++;
    end
    n_chk++;
    if (irqs != 1 || busy !== 1'b0 || m_ac !== 8'h12) begin
      n_fail++; $display("FAIL busy_start: got irqs=%0d busy=%b A=%h want 1/0/12", irqs, busy, m_ac);
    end
  endtask

  task automatic test_count_zero;
    bgnt = 1'b0; mack = 1'b0;
    mode = 3'b111; addr = 8'hFF; count = 8'h00;
    start = 1'b1;
    @(negedge cp);
    start = 1'b0;
    n_chk++;
    if (dout !== 8'h07) begin n_fail++; $display("FAIL zero_mode: got %h want 07", dout); end
    repeat (2) @(negedge cp);
    n_chk++;
    if ({i, doe, dout} !== {3'b110, 1'b1, 8'h00}) begin
      n_fail++; $display("FAIL zero_count: got i=%b doe=%b dout=%h want 110/1/00", i, doe, dout);
    end
    abort = 1'b1;
    @(negedge cp);
    abort = 1'b0;
    n_chk++;
    if ({busy, abt, doe} !== 3'b010) begin
      n_fail++; $display("FAIL zero_abort: got busy=%b abt=%b doe=%b want 010", busy, abt, doe);
    end
  endtask

  initial begin
    @(negedge cp);
    test_reset();
    test_basic();
    test_grant_loss();
    test_slow_mem();
    test_abort();
    test_reset_midxfer();
    test_busy_start();
    test_count_zero();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dma_xfer_ctl.md
DMA_XFER_CTL -- requirements
Module: dma_xfer_ctl

Interface
REQ-001 Parameter: W, 8, width of data/count path; one am2940 slice at the default.
REQ-002 Ports are listed as: name  direction  width  meaning.
REQ-003 cp  in  1  single clock; all state changes on rising edge.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 start  in  1  request block transfer; sampled only in IDLE.
REQ-006 mode  in  3  control word for am2940 CR[2:0].
REQ-007 addr  in  W  start address.
REQ-008 count  in  W  word count.
REQ-009 abort  in  1  cancel current block.
REQ-010 i  out  3  am2940 instruction.
REQ-011 dout  out  W  data driven onto am2940 D bus.
REQ-012 doe  out  1  dout drive enable.
REQ-013 aci_  out  1  am2940 address count enable, active-low.
REQ-014 wci_  out  1  am2940 word count enable, active-low.
REQ-015 oea_  out  1  am2940 address output enable, active-low.
REQ-016 done  in  1  am2940 DONE.
REQ-017 breq  out  1  bus request.
REQ-018 bgnt  in  1  bus grant.
REQ-019 mreq  out  1  memory cycle strobe.
REQ-020 mack  in  1  memory acknowledge.
REQ-021 busy  out  1  high in every state except IDLE.
REQ-022 irq  out  1  one-cycle completion pulse.
REQ-023 abt  out  1  sticky abort flag.

Function
REQ-024 Control SHALL be a registered FSM: IDLE, WRCR, LDAR, LDWC, REQ, XFER, STEP, FIN.
REQ-025 Outputs SHALL be Moore-decoded from the state register, except abt, which is a register.
REQ-026 Defaults in every state unless overridden: i=111, aci_=wci_=1, oea_=1, doe=0, dout=0, breq=mreq=irq=0.
REQ-027 IDLE: on start=1, latch mode/addr/count into internal registers, clear abt, and go to WRCR.
REQ-028 WRCR: i=000, doe=1, dout={0,mode}; next state LDAR.
REQ-029 LDAR: i=101, doe=1, dout=addr latch; next state LDWC.
REQ-030 LDWC: i=110, doe=1, dout=count latch; next state REQ.
REQ-031 REQ: breq=1; hold while bgnt=0; go to XFER on bgnt=1.
REQ-032 XFER: breq=1, mreq=1, oea_=0; hold while mack=0; on mack=1, latch last<=done and go to STEP.
REQ-033 STEP: breq=1, i=111, aci_=0, wci_=0 for exactly one cycle.
REQ-034 Exit from STEP: if last=1, go to FIN; else if bgnt=1, go to XFER; else go to REQ.
REQ-035 FIN: irq=1 for one cycle; next state IDLE.
REQ-036 start in any state other than IDLE SHALL be ignored.
REQ-037 abort=1 in any state other than IDLE: go to IDLE next edge and set abt=1; no STEP and no irq.
REQ-038 abort SHALL take priority over mack and bgnt in the same cycle.
REQ-039 Exactly one STEP pulse SHALL occur per acknowledged transfer; count enables SHALL never be asserted outside STEP.
REQ-040 Transfer count is governed solely by am2940 done; count=0 SHALL be passed through unchanged.
REQ-041 Setup latency: start sampled at edge k gives WRCR/LDAR/LDWC during cycles k+1..k+3 and breq from cycle k+4.

Reset
REQ-042 rst=1 at any edge, including mid-transfer, SHALL force IDLE.
REQ-043 rst SHALL clear abt, last, and the mode/addr/count latches.
REQ-044 Next cycle after rst: i=111, aci_=wci_=oea_=1, doe=0, breq=mreq=busy=irq=abt=0.
REQ-045 rst SHALL take priority over start and abort.

Verification
REQ-046 Reset: assert rst during an XFER -> next cycle all outputs at the REQ-044 values; no irq.
REQ-047 Basic block: mode=000, addr=0x08, count=0x03, bgnt=mack=1, with an am2940 model attached.
 -> dout sequence 0x00/0x08/0x03 with i=000/101/110.
 -> 3 XFER/STEP pairs; am2940 A goes 08,09,0A,0B.
 -> irq at the 11th cycle after start; then IDLE.
REQ-048 Grant loss: drop bgnt after the first STEP -> FSM returns to REQ, breq stays 1, mreq=0; resumes XFER one cycle after bgnt=1.
REQ-049 Slow memory: mack delayed 2 cycles -> XFER held 3 cycles; mreq=1 and oea_=0 throughout; aci_=wci_=1 until STEP.
REQ-050 Abort collision: abort=1 with mack=1 in XFER -> IDLE next cycle, abt=1, irq=0; am2940 A unchanged.
REQ-051 Busy start: second start pulse during REQ -> ignored; exactly one irq for the block.
